mmcm_drp_ctrl: RTL and testbench

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

---
 rtl/mmcm_drp_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_ctrl.sv
// MMCM DRP reconfiguration controller: read-modify-write of eight
// DRP registers per pixel-clock mode, then waits for MMCM lock.
module mmcm_drp_ctrl #(
  parameter int unsigned LOCK_TIMEOUT = 2**20,
  parameter int unsigned DRDY_TIMEOUT = 64
) (
  input  logic        CLKIN_100MHZ,
  input  logic        RESETN,
  input  logic        MODE,
  input  logic        REQ,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        CUR_MODE,
  output logic        MMCM_RST,
  output logic [6:0]  DADDR,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  output logic        DEN,
  output logic        DWE,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        LOCKED_SYNC
);

  localparam int unsigned TMAX =
    (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RST_ASSERT, RD, RD_WAIT,
    WR, WR_WAIT, RST_RELEASE, LOCK_WAIT
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] val;
  } rom_t;

  // {mode, index}: CLKOUT0 r1/r2, CLKFBOUT r1/r2, DIVCLK, LOCK r1/r2, FILTER r1
  function automatic rom_t rom_lookup(input logic m, input logic [2:0] i);
    rom_t r;
    r = '0;
    case ({m, i})
      4'h0: r = {7'h08, 16'h1000, 16'h0596};
      4'h1: r = {7'h09, 16'hFC00, 16'h0080};
      4'h2: r = {7'h14, 16'h1000, 16'h0A29};
      4'h3: r = {7'h15, 16'hFC00, 16'h0000};
      4'h4: r = {7'h16, 16'hC000, 16'h1041};
      4'h5: r = {7'h18, 16'hFC00, 16'h01E8};
      4'h6: r = {7'h19, 16'h8000, 16'h7001};
      4'h7: r = {7'h4E, 16'h66FF, 16'h1100};
      4'h8: r = {7'h08, 16'h1000, 16'h0659};
      4'h9: r = {7'h09, 16'hFC00, 16'h0040};
      4'hA: r = {7'h14, 16'h1000, 16'h0514};
      4'hB: r = {7'h15, 16'hFC00, 16'h0000};
      4'hC: r = {7'h16, 16'hC000, 16'h1041};
      4'hD: r = {7'h18, 16'hFC00, 16'h00FA};
      4'hE: r = {7'h19, 16'h8000, 16'h7C01};
      4'hF: r = {7'h4E, 16'h66FF, 16'h0800};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          cur_q, cur_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          den_q, den_d;
  logic          dwe_q, dwe_d;
  logic          rst_q, rst_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [15:0]   di_q, di_d;
  logic [1:0]    rsync_q;
  logic [1:0]    lsync_q;
  logic [2:0]    idx_sel;
  rom_t          ent;

  // WR_WAIT looks one entry ahead so DADDR is ready when RD starts
  assign idx_sel = (state_q == WR_WAIT) ? idx_q + 3'd1 : idx_q;
  assign ent     = rom_lookup(mode_q, idx_sel);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    err_d   = err_q;
    done_d  = 1'b0;
    daddr_d = daddr_q;
    di_d    = di_q;
    case (state_q)
      IDLE: begin
        if (REQ && rsync_q[1]) begin
          state_d = RST_ASSERT;
          mode_d  = MODE;
          err_d   = 1'b0;
          idx_d   = 3'd0;
        end
      end
      RST_ASSERT: begin
        idx_d   = 3'd0;
        daddr_d = ent.addr;
        state_d = RD;
      end
      RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (DRDY) begin
          di_d    = (DO & ent.mask) | ent.val;
          state_d = WR;
        end else if (cnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (DRDY) begin
          if (idx_q == 3'd7) begin
            state_d = RST_RELEASE;
          end else begin
            idx_d   = idx_sel;
            daddr_d = ent.addr;
            state_d = RD;
          end
        end else if (cnt_q == DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RST_RELEASE: begin
        cnt_d   = '0;
        state_d = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (lsync_q[1]) begin
          done_d  = 1'b1;
          cur_d   = mode_q;
          state_d = IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    den_d = (state_d == RD) || (state_d == WR);
    dwe_d = (state_d == WR);
    rst_d = (state_d == RST_ASSERT) || (state_d == RD) ||
            (state_d == RD_WAIT) || (state_d == WR) ||
            (state_d == WR_WAIT);
  end

  always_ff @(posedge CLKIN_100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      cur_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      rst_q   <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
      rsync_q <= '0;
      lsync_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      done_q  <= done_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      rst_q   <= rst_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
      rsync_q <= {rsync_q[0], 1'b1};
      lsync_q <= {lsync_q[0], LOCKED};
    end
  end

  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign ERROR       = err_q;
  assign CUR_MODE    = cur_q;
  assign MMCM_RST    = rst_q;
  assign DADDR       = daddr_q;
  assign DI          = di_q;
  assign DEN         = den_q;
  assign DWE         = dwe_q;
  assign LOCKED_SYNC = lsync_q[1];

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with a behavioural DRP/MMCM model.
// Expected DRP data tables are hand-computed from the register plan.
module tb_mmcm_drp_ctrl;

  logic        clk;
  logic        RESETN;
  logic        MODE;
  logic        REQ;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic        CUR_MODE;
  logic        MMCM_RST;
  logic [6:0]  DADDR;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DEN;
  logic        DWE;
  logic        DRDY;
  logic        LOCKED;
  logic        LOCKED_SYNC;

  mmcm_drp_ctrl #(
    .LOCK_TIMEOUT(1000),
    .DRDY_TIMEOUT(64)
  ) dut (
    .CLKIN_100MHZ(clk),
    .RESETN(RESETN),
    .MODE(MODE),
    .REQ(REQ),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERROR(ERROR),
    .CUR_MODE(CUR_MODE),
    .MMCM_RST(MMCM_RST),
    .DADDR(DADDR),
    .DI(DI),
    .DO(DO),
    .DEN(DEN),
    .DWE(DWE),
    .DRDY(DRDY),
    .LOCKED(LOCKED),
    .LOCKED_SYNC(LOCKED_SYNC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // model knobs
  logic [15:0] drp_do = 16'hFFFF;
  int          stuck_rd = 0;
  logic        bogus = 1'b0;
  logic        lock_en = 1'b1;

  // model state / logs
  int          cyc = 0;
  int          dcnt = 0;
  int          lcnt = 0;
  int          acc_n = 0;
  int          rd_n = 0;
  int          wr_n = 0;
  int          done_n = 0;
  int          err_cyc = 0;
  int          rst_fall_cyc = 0;
  logic        prev_err = 1'b0;
  logic        prev_rst = 1'b0;
  logic [6:0]  acc_addr [32];
  logic        acc_we   [32];
  logic [15:0] acc_di   [32];
  logic        acc_rst  [32];
  int          acc_cyc  [32];

  logic [6:0]  exp_addr [8] = '{7'h08, 7'h09, 7'h14, 7'h15,
                                7'h16, 7'h18, 7'h19, 7'h4E};
  logic [15:0] exp_di1  [8] = '{16'h1659, 16'hFC40, 16'h1514, 16'hFC00,
                                16'hD041, 16'hFCFA, 16'hFC01, 16'h6EFF};
  logic [15:0] exp_di0  [8] = '{16'h0596, 16'h0080, 16'h0A29, 16'h0000,
                                16'h1041, 16'h01E8, 16'h7001, 16'h1100};

  assign DO = drp_do;

  initial begin
    DRDY   = 1'b0;
    LOCKED = 1'b0;
  end

  // DRP slave: DRDY 3 cycles after DEN; MMCM lock 100 cycles after release
  always @(negedge clk) begin
    cyc++;
    DRDY = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) DRDY = 1'b1;
    end
    if (DEN) begin
      if (acc_n < 32) begin
        acc_addr[acc_n] = DADDR;
        acc_we[acc_n]   = DWE;
        acc_di[acc_n]   = DI;
        acc_rst[acc_n]  = MMCM_RST;
        acc_cyc[acc_n]  = cyc;
      end
      acc_n++;
      if (DWE) wr_n++;
      else rd_n++;
      if (bogus) DRDY = 1'b1;
      dcnt = (!DWE && rd_n == stuck_rd) ? 0 : 3;
    end
    if (DONE) done_n++;
    if (ERROR && !prev_err) err_cyc = cyc;
    prev_err = ERROR;
    if (!MMCM_RST && prev_rst) rst_fall_cyc = cyc;
    prev_rst = MMCM_RST;
    if (MMCM_RST || !lock_en) begin
      LOCKED = 1'b0;
      lcnt   = 0;
    end else if (!LOCKED) begin
      lcnt++;
      if (lcnt >= 100) LOCKED = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_log();
    acc_n  = 0;
    rd_n   = 0;
    wr_n   = 0;
    done_n = 0;
  endtask

  task automatic start(input logic m);
    MODE = m;
    REQ  = 1'b1;
    step();
    REQ  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (BUSY && k < budget) begin
      step();
      k++;
    end
    chk(tag, BUSY, 1'b0);
  endtask

  int n0;
  int nw;
  int k;

  initial begin
    RESETN = 1'b0;
    MODE   = 1'b0;
    REQ    = 1'b0;
    repeat (3) step();
    chk("reset_outs",
        {BUSY, DONE, ERROR, CUR_MODE, MMCM_RST, DEN, DWE,
         DADDR, DI, LOCKED_SYNC}, '0);

    // REQ in the first cycle after release is blocked by the reset synchronizer
    RESETN = 1'b1;
    REQ    = 1'b1;
    step();
    REQ    = 1'b0;
    chk("rst_sync_req", BUSY, 1'b0);
    repeat (4) step();

    // DRDY never returns for the 3rd read
    clear_log();
    stuck_rd = 3;
    start(1'b1);
    chk("a_busy", BUSY, 1'b1);
    wait_idle(500, "a_idle");
    chk("a_error", ERROR, 1'b1);
    chk("a_mmcm_rst", MMCM_RST, 1'b0);
    chk("a_done", done_n, 0);
    chk("a_cur_mode", CUR_MODE, 1'b0);
    chk("a_rd_n", rd_n, 3);
    chk("a_wr_n", wr_n, 2);
    chk("a_timeout_cyc", err_cyc - acc_cyc[4], 65);
    stuck_rd = 0;

    // mode 1, DO = FFFF
    clear_log();
    start(1'b1);
    chk("b_err_clr", ERROR, 1'b0);
    wait_idle(2000, "b_idle");
    chk("b_acc_n", acc_n, 16);
    for (int i = 0; i < 16; i++) begin
      chk("b_addr", acc_addr[i], exp_addr[i/2]);
      chk("b_we", acc_we[i], i % 2);
      chk("b_rst_hi", acc_rst[i], 1'b1);
    end
    for (int i = 0; i < 8; i++) chk("b_di", acc_di[2*i+1], exp_di1[i]);
    chk("b_done", done_n, 1);
    chk("b_cur_mode", CUR_MODE, 1'b1);
    chk("b_error", ERROR, 1'b0);
    chk("b_mmcm_rst", MMCM_RST, 1'b0);

    // mode 0, DO = 0000, bogus DRDY alongside every DEN
    clear_log();
    drp_do = 16'h0000;
    bogus  = 1'b1;
    start(1'b0);
    wait_idle(2000, "c_idle");
    chk("c_acc_n", acc_n, 16);
    for (int i = 0; i < 8; i++) chk("c_di", acc_di[2*i+1], exp_di0[i]);
    chk("c_done", done_n, 1);
    chk("c_cur_mode", CUR_MODE, 1'b0);
    bogus  = 1'b0;
    drp_do = 16'hFFFF;

    // second REQ with toggled MODE while busy is dropped
    clear_log();
    start(1'b1);
    repeat (20) step();
    MODE = 1'b0;
    REQ  = 1'b1;
    step();
    REQ  = 1'b0;
    wait_idle(2000, "d_idle");
    repeat (30) step();
    chk("d_busy", BUSY, 1'b0);
    chk("d_acc_n", acc_n, 16);
    chk("d_di1", acc_di[1], 16'h1659);
    chk("d_di15", acc_di[15], 16'h6EFF);
    chk("d_cur_mode", CUR_MODE, 1'b1);
    chk("d_done", done_n, 1);

    // LOCKED dropping while idle only moves LOCKED_SYNC
    chk("e_lsync_hi", LOCKED_SYNC, 1'b1);
    lock_en = 1'b0;
    repeat (3) step();
    chk("e_lsync_lo", LOCKED_SYNC, 1'b0);
    chk("e_busy", BUSY, 1'b0);

    // lock timeout, then a good retry clears ERROR
    clear_log();
    start(1'b0);
    wait_idle(3000, "e_idle");
    chk("e_error", ERROR, 1'b1);
    chk("e_lock_cyc", err_cyc - rst_fall_cyc, 1001);
    chk("e_cur_mode", CUR_MODE, 1'b1);
    chk("e_done", done_n, 0);
    lock_en = 1'b1;
    clear_log();
    start(1'b0);
    chk("e2_err_clr", ERROR, 1'b0);
    wait_idle(2000, "e2_idle");
    chk("e2_done", done_n, 1);
    chk("e2_cur_mode", CUR_MODE, 1'b0);
    chk("e2_error", ERROR, 1'b0);

    // reset during the 5th write
    clear_log();
    start(1'b1);
    k  = 0;
    nw = 0;
    while (nw < 5 && k < 1000) begin
      step();
      k++;
      if (DEN && DWE) nw++;
    end
    chk("f_wr5", nw, 5);
    chk("f_pre", {DEN, DWE, MMCM_RST}, 3'b111);
    RESETN = 1'b0;
    #1;
    chk("f_reset_outs",
        {BUSY, DONE, ERROR, CUR_MODE, MMCM_RST, DEN, DWE,
         DADDR, DI, LOCKED_SYNC}, '0);
    n0 = acc_n;
    repeat (3) step();
    RESETN = 1'b1;
    repeat (40) step();
    chk("f_no_den", acc_n, n0);
    chk("f_busy", BUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
